// File: rtl/mesi_isc_breq_fifos_param.sv
// Broadcast-request queue stage of the MESI coherence controller.
// Each CPU port owns a small FIFO of broadcast requests (WR_BROAD / RD_BROAD).
// A round-robin arbiter drains one FIFO per cycle into the downstream
// broadcast FIFO, tagging each entry with {cpu id, per-CPU sequence number}.
module mesi_isc_breq_fifos_param #(
  parameter int NUM_CPUS            = 4,
  parameter int CPU_ID_WIDTH        = 2,
  parameter int MBUS_CMD_WIDTH      = 3,
  parameter int ADDR_WIDTH          = 32,
  parameter int BROAD_TYPE_WIDTH    = 2,
  parameter int BROAD_ID_WIDTH      = 7,
  parameter int BREQ_FIFO_SIZE      = 2,
  parameter int BREQ_FIFO_SIZE_LOG2 = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_CPUS*MBUS_CMD_WIDTH-1:0]   mbus_cmd_array_i,
  input  logic [NUM_CPUS*ADDR_WIDTH-1:0]       mbus_addr_array_i,
  input  logic [NUM_CPUS-1:0]                  port_en_i,
  input  logic                                 broad_fifo_status_full_i,
  output logic [NUM_CPUS-1:0]                  mbus_ack_array_o,
  output logic                                 broad_fifo_wr_o,
  output logic [ADDR_WIDTH-1:0]                broad_addr_o,
  output logic [BROAD_TYPE_WIDTH-1:0]          broad_type_o,
  output logic [CPU_ID_WIDTH-1:0]              broad_cpu_id_o,
  output logic [BROAD_ID_WIDTH-1:0]            broad_id_o,
  output logic [NUM_CPUS-1:0]                  fifo_status_empty_array_o,
  output logic [NUM_CPUS-1:0]                  fifo_status_full_array_o
);

  localparam int SEQ_WIDTH   = BROAD_ID_WIDTH - CPU_ID_WIDTH;
  localparam int CNT_WIDTH   = BREQ_FIFO_SIZE_LOG2 + 1;
  localparam int ENTRY_WIDTH = ADDR_WIDTH + BROAD_TYPE_WIDTH + SEQ_WIDTH;

  localparam logic [MBUS_CMD_WIDTH-1:0]   CMD_WR_BROAD = MBUS_CMD_WIDTH'(3);
  localparam logic [MBUS_CMD_WIDTH-1:0]   CMD_RD_BROAD = MBUS_CMD_WIDTH'(4);
  localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_WR      = BROAD_TYPE_WIDTH'(1);
  localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_RD      = BROAD_TYPE_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0]        FIFO_DEPTH   = CNT_WIDTH'(BREQ_FIFO_SIZE);
  localparam logic [CPU_ID_WIDTH-1:0]     LAST_CPU     = CPU_ID_WIDTH'(NUM_CPUS - 1);

  // Entry layout: {addr, type, seq}
  logic [ENTRY_WIDTH-1:0]      head_entry [NUM_CPUS];
  logic [NUM_CPUS-1:0]         fifo_empty;
  logic [NUM_CPUS-1:0]         fifo_full;
  logic [NUM_CPUS-1:0]         ack_vec;

  logic [CPU_ID_WIDTH-1:0]     last_grant_q;
  logic [CPU_ID_WIDTH-1:0]     grant_idx;
  logic                        grant_valid;
  logic                        pop_en;
  logic [ENTRY_WIDTH-1:0]      grant_entry;

  logic                        wr_q;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic [BROAD_TYPE_WIDTH-1:0] type_q;
  logic [CPU_ID_WIDTH-1:0]     cpu_id_q;
  logic [BROAD_ID_WIDTH-1:0]   id_q;

  // CPU index 'offset' positions after 'base', wrapping at NUM_CPUS
  // (NUM_CPUS need not be a power of two).
  function automatic logic [CPU_ID_WIDTH-1:0] rr_index(
    input logic [CPU_ID_WIDTH-1:0] base,
    input int                      offset
  );
    return CPU_ID_WIDTH'((int'(base) + offset) % NUM_CPUS);
  endfunction

  // Per-CPU request FIFO, acceptance handshake and sequence counter
  for (genvar gi = 0; gi < NUM_CPUS; gi++) begin : g_cpu
    logic [MBUS_CMD_WIDTH-1:0]      cmd;
    logic [ADDR_WIDTH-1:0]          addr;
    logic                           is_broad;
    logic                           accept;
    logic                           pop;
    logic [BROAD_TYPE_WIDTH-1:0]    entry_type;
    logic [BREQ_FIFO_SIZE_LOG2-1:0] wr_ptr_q;
    logic [BREQ_FIFO_SIZE_LOG2-1:0] rd_ptr_q;
    logic [CNT_WIDTH-1:0]           count_q;
    logic [CNT_WIDTH-1:0]           count_d;
    logic [SEQ_WIDTH-1:0]           seq_q;
    logic                           ack_q;
    logic                           empty_q;
    logic                           full_q;
    logic [ENTRY_WIDTH-1:0]         mem_q [BREQ_FIFO_SIZE];

    assign cmd        = mbus_cmd_array_i[gi*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH];
    assign addr       = mbus_addr_array_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign is_broad   = (cmd == CMD_WR_BROAD) || (cmd == CMD_RD_BROAD);
    // full_q is the pre-edge occupancy, so a same-cycle pop never makes room
    // for a write; ack_q blocks a second accept while the ack is visible.
    assign accept     = is_broad && port_en_i[gi] && !full_q && !ack_q;
    assign pop        = pop_en && (grant_idx == CPU_ID_WIDTH'(gi));
    assign entry_type = (cmd == CMD_WR_BROAD) ? TYPE_WR : TYPE_RD;

    // Occupancy after this edge
    always_comb begin
      count_d = count_q;
      if (accept && !pop) begin
        count_d = count_q + 1'b1;
      end else if (!accept && pop) begin
        count_d = count_q - 1'b1;
      end
    end

    // Pointers, sequence counter, ack pulse and registered status flags
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        seq_q    <= '0;
        ack_q    <= 1'b0;
        empty_q  <= 1'b1;
        full_q   <= 1'b0;
      end else begin
        if (accept) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
          seq_q    <= seq_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
        count_q <= count_d;
        ack_q   <= accept;
        empty_q <= (count_d == '0);
        full_q  <= (count_d == FIFO_DEPTH);
      end
    end

    // Entry storage; no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
      if (accept) begin
        mem_q[wr_ptr_q] <= {addr, entry_type, seq_q};
      end
    end

    assign head_entry[gi] = mem_q[rd_ptr_q];
    assign fifo_empty[gi] = empty_q;
    assign fifo_full[gi]  = full_q;
    assign ack_vec[gi]    = ack_q;
  end

  // Round-robin pick: first non-empty FIFO after the last granted CPU
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_CPUS; k++) begin
      if (!grant_valid && !fifo_empty[rr_index(last_grant_q, k)]) begin
        grant_valid = 1'b1;
        grant_idx   = rr_index(last_grant_q, k);
      end
    end
  end

  assign pop_en      = grant_valid && !broad_fifo_status_full_i;
  assign grant_entry = head_entry[grant_idx];

  // Broadcast output register and arbitration pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q         <= 1'b0;
      addr_q       <= '0;
      type_q       <= '0;
      cpu_id_q     <= '0;
      id_q         <= '0;
      last_grant_q <= LAST_CPU;
    end else begin
      wr_q <= pop_en;
      if (pop_en) begin
        last_grant_q <= grant_idx;
        addr_q       <= grant_entry[ENTRY_WIDTH-1 -: ADDR_WIDTH];
        type_q       <= grant_entry[SEQ_WIDTH +: BROAD_TYPE_WIDTH];
        cpu_id_q     <= grant_idx;
        id_q         <= {grant_idx, grant_entry[SEQ_WIDTH-1:0]};
      end
    end
  end

  assign mbus_ack_array_o          = ack_vec;
  assign broad_fifo_wr_o           = wr_q;
  assign broad_addr_o              = addr_q;
  assign broad_type_o              = type_q;
  assign broad_cpu_id_o            = cpu_id_q;
  assign broad_id_o                = id_q;
  assign fifo_status_empty_array_o = fifo_empty;
  assign fifo_status_full_array_o  = fifo_full;

endmodule
